// File: rtl/adr_gen_scan_pkg.sv
// Shared opcodes, FSM states and sizing helpers for the address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adr_gen_scan_pkg;

  // Command opcodes carried on cmd_op; 6 and 7 decode as NOP.
  typedef enum logic [2:0] {
    ADR_OP_NOP      = 3'd0,
    ADR_OP_MATRIX_R = 3'd1,
    ADR_OP_MATRIX_W = 3'd2,
    ADR_OP_LOAD_SEG = 3'd3,
    ADR_OP_SCAN     = 3'd4,
    ADR_OP_ABORT    = 3'd5
  } adr_op_e;

  // Scan engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } adr_state_e;

  // Number of DW-wide load segments needed to cover an AW-bit address.
  function automatic int nseg_of(input int aw, input int dw);
    return (aw + dw - 1) / dw;
  endfunction

  // Segment index width, never narrower than one bit.
  function automatic int seg_w(input int nseg);
    return (nseg <= 1) ? 1 : $clog2(nseg);
  endfunction

endpackage

// File: rtl/adr_gen_scan_if.sv
// Command, coordinate and address/scan-stream bundle of the address generator.
// Latency: n/a (wiring only).
// Backpressure: scan stream uses dout_valid/out_ready.
interface adr_gen_scan_if
  import adr_gen_scan_pkg::*;
#(
  parameter int CW = 8,
  parameter int DW = 8
);
  localparam int AW   = 2 * CW + 2;
  localparam int NSEG = nseg_of(AW, DW);
  localparam int SW   = seg_w(NSEG);

  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [SW-1:0] cmd_seg;
  logic [DW-1:0] din;
  logic [CW-1:0] art;
  logic [CW-1:0] arg;
  logic [CW-1:0] awt;
  logic [CW-1:0] awg;
  logic          tog_inc;
  logic          quad_inc;
  logic          out_ready;
  logic [AW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          scan_done;
  logic [1:0]    quad_out;
  logic          quad_z;
  logic          tog;

  modport master (
    output cmd_valid, cmd_op, cmd_seg, din, art, arg, awt, awg,
           tog_inc, quad_inc, out_ready,
    input  dout, dout_valid, busy, scan_done, quad_out, quad_z, tog
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_seg, din, art, arg, awt, awg,
           tog_inc, quad_inc, out_ready,
    output dout, dout_valid, busy, scan_done, quad_out, quad_z, tog
  );

endinterface

// File: rtl/adr_gen_scan_compose.sv
// Forms a matrix address {q1, hi, q0, lo} from quadrant, T/G coordinates and transpose flag.
// Latency: combinational.
// Backpressure: none.
module adr_gen_scan_compose #(
  parameter int CW = 8
) (
  input  logic [1:0]      quad_i,
  input  logic            tog_i,
  input  logic [CW-1:0]   t_i,
  input  logic [CW-1:0]   g_i,
  output logic [2*CW+1:0] adr_o
);

  // Transpose swaps which coordinate lands in the high and low fields.
  always_comb begin
    if (tog_i) adr_o = {quad_i[1], t_i, quad_i[0], g_i};
    else       adr_o = {quad_i[1], g_i, quad_i[0], t_i};
  end

endmodule

// File: rtl/adr_gen_scan.sv
// Matrix address generator with segment load and a self-timed quadrant scan engine.
// Latency: commands registered on the accepting edge (1 cycle); scan beat per accepted cycle.
// Backpressure: scan holds dout/dout_valid while out_ready is low. Option: ADR_SCAN_AUTOQUAD_EN.
module adr_gen_scan
  import adr_gen_scan_pkg::*;
#(
  parameter int CW  = 8,
  parameter int DW  = 8,
  parameter int DIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  adr_gen_scan_if.slave bus
);

  localparam int AW   = 2 * CW + 2;
  localparam int NSEG = nseg_of(AW, DW);
  localparam int SW   = seg_w(NSEG);
  localparam int PW   = NSEG * DW;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  adr_state_e    state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [CW-1:0] g_q, g_d;
  logic [AW-1:0] dout_q, dout_d;
  logic          tog_q, tog_d;
  logic [1:0]    quad_q, quad_d;

  logic [CW-1:0] comp_t, comp_g;
  logic [AW-1:0] comp_adr;
  logic [CW-1:0] nxt_t, nxt_g;
  logic          last_t, last_beat;
  logic [PW-1:0] seg_pad;
  logic          is_abort;

  // Raster order: T runs fastest, G advances when T wraps.
  assign last_t    = (t_q == LAST);
  assign last_beat = last_t && (g_q == LAST);
  assign nxt_t     = last_t ? '0 : t_q + CW'(1);
  assign nxt_g     = last_t ? g_q + CW'(1) : g_q;
  assign is_abort  = bus.cmd_valid && (bus.cmd_op == ADR_OP_ABORT);

  // Coordinate source for the shared composer: matrix ports, scan origin or next scan point.
  always_comb begin
    comp_t = nxt_t;
    comp_g = nxt_g;
    if (state_q == ST_IDLE) begin
      comp_t = '0;
      comp_g = '0;
      if (bus.cmd_valid && bus.cmd_op == ADR_OP_MATRIX_R) begin
        comp_t = bus.art;
        comp_g = bus.arg;
      end else if (bus.cmd_valid && bus.cmd_op == ADR_OP_MATRIX_W) begin
        comp_t = bus.awt;
        comp_g = bus.awg;
      end
    end
  end

  adr_gen_scan_compose #(.CW(CW)) u_compose (
    .quad_i (quad_q),
    .tog_i  (tog_q),
    .t_i    (comp_t),
    .g_i    (comp_g),
    .adr_o  (comp_adr)
  );

  // Segment overlay on a padded copy so the top segment may hang past AW; out-of-range seg matches nothing.
  always_comb begin
    seg_pad = PW'(dout_q);
    for (int s = 0; s < NSEG; s++) begin
      if (bus.cmd_seg == SW'(s)) seg_pad[s*DW +: DW] = bus.din;
    end
  end

  // Next-state: command decode in IDLE, beat stepping in SCAN, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    g_d     = g_q;
    dout_d  = dout_q;
    tog_d   = tog_q;
    quad_d  = quad_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tog_inc)  tog_d  = ~tog_q;
        if (bus.quad_inc) quad_d = quad_q + 2'd1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            ADR_OP_MATRIX_R,
            ADR_OP_MATRIX_W: dout_d = comp_adr;
            ADR_OP_LOAD_SEG: dout_d = seg_pad[AW-1:0];
            ADR_OP_SCAN: begin
              t_d     = '0;
              g_d     = '0;
              dout_d  = comp_adr;
              state_d = ST_SCAN;
            end
            default: ;
          endcase
        end
      end
      ST_SCAN: begin
        if (is_abort) begin
          state_d = ST_IDLE;
        end else if (bus.out_ready) begin
          if (last_beat) begin
            state_d = ST_DONE;
`ifdef ADR_SCAN_AUTOQUAD_EN
            quad_d  = quad_q + 2'd1;
`endif
          end else begin
            t_d    = nxt_t;
            g_d    = nxt_g;
            dout_d = comp_adr;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      g_q     <= '0;
      dout_q  <= '0;
      tog_q   <= 1'b0;
      quad_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      g_q     <= g_d;
      dout_q  <= dout_d;
      tog_q   <= tog_d;
      quad_q  <= quad_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == ST_SCAN);
  assign bus.busy       = (state_q == ST_SCAN);
  assign bus.scan_done  = (state_q == ST_DONE);
  assign bus.quad_out   = quad_q;
  assign bus.quad_z     = (quad_q == 2'd0);
  assign bus.tog        = tog_q;

endmodule

// File: tb/tb_adr_gen_scan.sv
// Directed plus randomized bench for adr_gen_scan against an arithmetic address model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: random and directed out_ready stalls on the scan stream.
module tb_adr_gen_scan;
  import adr_gen_scan_pkg::*;

  localparam int CW  = 8;
  localparam int DW  = 8;
  localparam int DIM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  adr_gen_scan_if #(.CW(CW), .DW(DW)) bus ();

  adr_gen_scan #(.CW(CW), .DW(DW), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          m_quad;
  bit          m_tog;
  logic [17:0] m_dout;
  logic [17:0] exp_q[$];

  // Address = q1*2^17 + hi*2^9 + q0*2^8 + lo, hi/lo chosen by the transpose flag.
  function automatic logic [17:0] ref_adr(input int q, input bit tg, input int t, input int g);
    int hi, lo;
    hi = tg ? t : g;
    lo = tg ? g : t;
    return 18'((q / 2) * 131072 + hi * 512 + (q % 2) * 256 + lo);
  endfunction

  task automatic chkv(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    cyc();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
  endtask

  task automatic build_scan();
    exp_q.delete();
    for (int g = 0; g < DIM; g++)
      for (int t = 0; t < DIM; t++)
        exp_q.push_back(ref_adr(m_quad, m_tog, t, g));
  endtask

  task automatic set_qt(input int q, input bit tg);
    while (m_quad != q) begin
      bus.quad_inc = 1'b1;
      cyc();
      m_quad = (m_quad + 1) % 4;
    end
    bus.quad_inc = 1'b0;
    if (m_tog != tg) begin
      bus.tog_inc = 1'b1;
      cyc();
      bus.tog_inc = 1'b0;
      m_tog = tg;
    end
  endtask

  task automatic done_check(input string tag);
    chk1({tag, "_done_pulse"}, bus.scan_done, 1'b1);
    chk1({tag, "_done_valid"}, bus.dout_valid, 1'b0);
    chk1({tag, "_done_busy"}, bus.busy, 1'b0);
    chkv({tag, "_done_dout"}, bus.dout, m_dout);
`ifdef ADR_SCAN_AUTOQUAD_EN
    m_quad = (m_quad + 1) % 4;
`endif
    chkv({tag, "_done_quad"}, 18'(bus.quad_out), 18'(m_quad));
    cyc();
    chk1({tag, "_done_end"}, bus.scan_done, 1'b0);
  endtask

  initial begin
    int idx;
    int cnt;
    logic [23:0] seg_v;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_seg   = '0;
    bus.din       = '0;
    bus.art       = '0;
    bus.arg       = '0;
    bus.awt       = '0;
    bus.awg       = '0;
    bus.tog_inc   = 1'b0;
    bus.quad_inc  = 1'b0;
    bus.out_ready = 1'b1;
    m_quad = 0;
    m_tog  = 1'b0;
    m_dout = '0;

    // Reset state
    repeat (2) cyc();
    chkv("rst_dout", bus.dout, 18'h0);
    chk1("rst_valid", bus.dout_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.scan_done, 1'b0);
    chkv("rst_quad", 18'(bus.quad_out), 18'h0);
    chk1("rst_quad_z", bus.quad_z, 1'b1);
    chk1("rst_tog", bus.tog, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Matrix read, then quadrant/transpose changes
    bus.art = 8'h12;
    bus.arg = 8'h34;
    do_cmd(ADR_OP_MATRIX_R);
    m_dout = ref_adr(m_quad, m_tog, 'h12, 'h34);
    chkv("mtx_r0", bus.dout, 18'h06812);
    set_qt(3, 1'b1);
    chkv("quad3", 18'(bus.quad_out), 18'd3);
    chk1("quad3_z", bus.quad_z, 1'b0);
    chk1("tog1", bus.tog, 1'b1);
    do_cmd(ADR_OP_MATRIX_R);
    chkv("mtx_r1", bus.dout, 18'h22534);
    bus.awt = 8'hA5;
    bus.awg = 8'h3C;
    do_cmd(ADR_OP_MATRIX_W);
    chkv("mtx_w", bus.dout, ref_adr(3, 1'b1, 'hA5, 'h3C));
    set_qt(0, 1'b0);
    chkv("quad_wrap", 18'(bus.quad_out), 18'd0);
    chk1("quad_wrap_z", bus.quad_z, 1'b1);

    // Segment loads, top segment truncated, out-of-range segment ignored
    seg_v = 24'(bus.dout);
    for (int s = 0; s < 4; s++) begin
      bus.cmd_seg = 2'(s);
      bus.din     = (s == 0) ? 8'hAB : (s == 1) ? 8'hCD : (s == 2) ? 8'hFF : 8'h55;
      if (s < 3) seg_v[s*8 +: 8] = bus.din;
      do_cmd(ADR_OP_LOAD_SEG);
      chkv($sformatf("load_seg%0d", s), bus.dout, seg_v[17:0]);
    end
    chkv("load_final", bus.dout, 18'h3CDAB);

    // Full scan, consumer always ready
    build_scan();
    bus.out_ready = 1'b1;
    do_cmd(ADR_OP_SCAN);
    chk1("scan_busy", bus.busy, 1'b1);
    for (int i = 0; i < DIM * DIM; i++) begin
      chk1($sformatf("scan_valid%0d", i), bus.dout_valid, 1'b1);
      chkv($sformatf("scan_beat%0d", i), bus.dout, exp_q[i]);
      cyc();
    end
    m_dout = exp_q[DIM*DIM-1];
    done_check("scan");

    // Scan with a 3-cycle stall on the fifth beat
    build_scan();
    do_cmd(ADR_OP_SCAN);
    for (int i = 0; i < DIM * DIM; i++) begin
      if (i == 4) begin
        bus.out_ready = 1'b0;
        repeat (3) begin
          chkv("stall_hold", bus.dout, exp_q[4]);
          chk1("stall_valid", bus.dout_valid, 1'b1);
          cyc();
        end
        bus.out_ready = 1'b1;
      end
      chkv($sformatf("stall_beat%0d", i), bus.dout, exp_q[i]);
      cyc();
    end
    m_dout = exp_q[DIM*DIM-1];
    done_check("stall");

    // Random matrix ops with simultaneous transpose/quadrant updates
    for (int i = 0; i < 10; i++) begin
      logic rd;
      rd           = 1'($urandom_range(0, 1));
      bus.art      = 8'($urandom);
      bus.arg      = 8'($urandom);
      bus.awt      = 8'($urandom);
      bus.awg      = 8'($urandom);
      bus.tog_inc  = 1'($urandom_range(0, 1));
      bus.quad_inc = 1'($urandom_range(0, 1));
      m_dout = rd ? ref_adr(m_quad, m_tog, int'(bus.art), int'(bus.arg))
                  : ref_adr(m_quad, m_tog, int'(bus.awt), int'(bus.awg));
      if (bus.tog_inc) m_tog = ~m_tog;
      if (bus.quad_inc) m_quad = (m_quad + 1) % 4;
      do_cmd(rd ? 3'(ADR_OP_MATRIX_R) : 3'(ADR_OP_MATRIX_W));
      bus.tog_inc  = 1'b0;
      bus.quad_inc = 1'b0;
      chkv("rand_mtx", bus.dout, m_dout);
      chkv("rand_quad", 18'(bus.quad_out), 18'(m_quad));
      chk1("rand_tog", bus.tog, m_tog);
    end

    // Scan under random backpressure, bounded
    build_scan();
    do_cmd(ADR_OP_SCAN);
    idx = 0;
    cnt = 0;
    while (idx < DIM * DIM && cnt < 400) begin
      if (bus.dout_valid) chkv("rscan_beat", bus.dout, exp_q[idx]);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.dout_valid && bus.out_ready) idx++;
      cyc();
      cnt++;
    end
    bus.out_ready = 1'b1;
    chkv("rscan_beats", 18'(idx), 18'(DIM * DIM));
    m_dout = exp_q[DIM*DIM-1];
    done_check("rscan");

    // Abort at the eighth beat; quad_inc/tog_inc held during the scan are ignored
    set_qt(0, 1'b0);
    build_scan();
    do_cmd(ADR_OP_SCAN);
    bus.quad_inc = 1'b1;
    bus.tog_inc  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chkv($sformatf("abort_beat%0d", i), bus.dout, exp_q[i]);
      cyc();
    end
    bus.quad_inc  = 1'b0;
    bus.tog_inc   = 1'b0;
    do_cmd(ADR_OP_ABORT);
    chk1("abort_valid", bus.dout_valid, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_done", bus.scan_done, 1'b0);
    chkv("abort_quad", 18'(bus.quad_out), 18'd0);
    chk1("abort_tog", bus.tog, 1'b0);
    cyc();
    chk1("abort_done2", bus.scan_done, 1'b0);
    chk1("abort_valid2", bus.dout_valid, 1'b0);

    // Asynchronous reset in the middle of a scan
    set_qt(2, 1'b1);
    do_cmd(ADR_OP_SCAN);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chkv("arst_dout", bus.dout, 18'h0);
    chk1("arst_valid", bus.dout_valid, 1'b0);
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_quad_z", bus.quad_z, 1'b1);
    chk1("arst_tog", bus.tog, 1'b0);
    m_quad = 0;
    m_tog  = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk1("post_rst_valid", bus.dout_valid, 1'b0);
    chkv("post_rst_quad", 18'(bus.quad_out), 18'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
